// File: rtl/matvec_pkg.sv
// Shared types and constants for the streaming matrix-vector core.
package matvec_pkg;

    typedef enum logic [2:0] {StHdr, StLoadVec, StMac, StEmit, StDrain} state_e;

    localparam int unsigned HdrRowsLsb = 16;
    localparam int unsigned HdrColsLsb = 0;
    localparam int unsigned HdrFieldW  = 16;

    localparam logic [31:0] ErrWord = 32'h8000_0000;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [127:0] sat_clamp(input logic signed [127:0] v,
                                                      input int unsigned w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/matvec_vec_buf.sv
// Vector operand store: synchronous write, combinational read.
module matvec_vec_buf
    import matvec_pkg::*;
#(
    parameter int unsigned MAX_DIM = 64,
    parameter int unsigned ELEM_W  = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(MAX_DIM)-1:0] waddr,
    input  logic [ELEM_W-1:0]          wdata,
    input  logic [$clog2(MAX_DIM)-1:0] raddr,
    output logic [ELEM_W-1:0]          rdata
);

    logic [ELEM_W-1:0] mem [MAX_DIM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/matvec_stream_core.sv
// Streaming matrix-vector multiply core: header, vector, row-major matrix in; one word per row out.
// Optional build macro MATVEC_SAT_EN clamps each row result to the signed DATA_W range.
module matvec_stream_core
    import matvec_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ELEM_W  = 16,
    parameter int unsigned ACC_W   = 48,
    parameter int unsigned MAX_DIM = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   M_AXIS_Recive_tdata,
    input  logic                M_AXIS_Recive_tvalid,
    input  logic                M_AXIS_Recive_tlast,
    output logic                M_AXIS_Recive_tready,
    output logic [DATA_W-1:0]   S_AXIS_Send_tdata,
    output logic [DATA_W/8-1:0] S_AXIS_Send_tkeep,
    output logic                S_AXIS_Send_tvalid,
    output logic                S_AXIS_Send_tlast,
    input  logic                S_AXIS_Send_tready,
    input  logic                axi_send_fifo_almost_full_0,
    output logic                busy,
    output logic                err
);

    localparam int unsigned CntW  = $clog2(MAX_DIM + 1);
    localparam int unsigned IdxW  = $clog2(MAX_DIM);
    localparam int unsigned KeepW = DATA_W / 8;

    state_e                   state_q, ret_q;
    logic [CntW-1:0]          rows_q, cols_q, row_q, col_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     err_q, err_pend_q, rdy_en_q;
    logic [DATA_W-1:0]        tdata_q;
    logic [KeepW-1:0]         tkeep_q;
    logic                     tvalid_q, tlast_q;

    logic                     rdy, accept, in_last, last_col, last_row;
    logic [HdrFieldW-1:0]     hdr_rows, hdr_cols;
    logic                     hdr_legal;
    logic signed [ELEM_W-1:0] elem_in, vec_elem;
    logic [ELEM_W-1:0]        vec_raw;
    logic signed [2*ELEM_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_base, acc_sum;
    logic [DATA_W-1:0]        result;

    assign hdr_rows  = M_AXIS_Recive_tdata[HdrRowsLsb +: HdrFieldW];
    assign hdr_cols  = M_AXIS_Recive_tdata[HdrColsLsb +: HdrFieldW];
    assign hdr_legal = (hdr_rows != '0) && (hdr_cols != '0) &&
                       (hdr_rows <= HdrFieldW'(MAX_DIM)) && (hdr_cols <= HdrFieldW'(MAX_DIM));

    // Only the first word of a row waits on almost_full; a row already started runs to completion.
    always_comb begin
        rdy = 1'b0;
        unique case (state_q)
            StHdr, StLoadVec, StDrain: rdy = 1'b1;
            StMac:                     rdy = !((col_q == '0) && axi_send_fifo_almost_full_0);
            default:                   rdy = 1'b0;
        endcase
    end

    assign M_AXIS_Recive_tready = rdy & rdy_en_q;
    assign accept   = M_AXIS_Recive_tvalid & M_AXIS_Recive_tready;
    assign in_last  = M_AXIS_Recive_tlast;
    assign last_col = (col_q == cols_q - CntW'(1));
    assign last_row = (row_q == rows_q - CntW'(1));

    matvec_vec_buf #(
        .MAX_DIM (MAX_DIM),
        .ELEM_W  (ELEM_W)
    ) u_vec_buf (
        .clk   (clk),
        .we    (accept && (state_q == StLoadVec)),
        .waddr (col_q[IdxW-1:0]),
        .wdata (M_AXIS_Recive_tdata[ELEM_W-1:0]),
        .raddr (col_q[IdxW-1:0]),
        .rdata (vec_raw)
    );

    assign elem_in  = M_AXIS_Recive_tdata[ELEM_W-1:0];
    assign vec_elem = vec_raw;
    assign prod     = (2*ELEM_W)'(elem_in) * (2*ELEM_W)'(vec_elem);
    assign acc_base = (col_q == '0) ? '0 : acc_q;
    assign acc_sum  = acc_base + ACC_W'(prod);

`ifdef MATVEC_SAT_EN
    assign result = DATA_W'(sat_clamp(128'(acc_sum), DATA_W));
`else
    assign result = acc_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHdr;
            ret_q      <= StHdr;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            rdy_en_q   <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            unique case (state_q)
                StHdr: begin
                    if (accept) begin
                        rows_q <= CntW'(hdr_rows);
                        cols_q <= CntW'(hdr_cols);
                        row_q  <= '0;
                        col_q  <= '0;
                        if (hdr_legal && !in_last) begin
                            err_q   <= 1'b0;
                            state_q <= StLoadVec;
                        end else if (hdr_legal || !in_last) begin
                            err_q      <= 1'b1;
                            err_pend_q <= 1'b1;
                            state_q    <= StDrain;
                        end else begin
                            err_q    <= 1'b1;
                            tdata_q  <= DATA_W'(ErrWord);
                            tlast_q  <= 1'b1;
                            tkeep_q  <= '1;
                            tvalid_q <= 1'b1;
                            ret_q    <= StHdr;
                            state_q  <= StEmit;
                        end
                    end
                end
                StLoadVec: begin
                    if (accept) begin
                        if (in_last) begin
                            err_q      <= 1'b1;
                            err_pend_q <= 1'b1;
                            state_q    <= StDrain;
                        end else if (last_col) begin
                            col_q   <= '0;
                            state_q <= StMac;
                        end else begin
                            col_q <= col_q + CntW'(1);
                        end
                    end
                end
                StMac: begin
                    if (accept) begin
                        acc_q <= acc_sum;
                        if (last_col) begin
                            col_q    <= '0;
                            tkeep_q  <= '1;
                            tvalid_q <= 1'b1;
                            state_q  <= StEmit;
                            if (last_row) begin
                                tdata_q <= result;
                                tlast_q <= 1'b1;
                                ret_q   <= in_last ? StHdr : StDrain;
                                if (!in_last) begin
                                    err_q <= 1'b1;
                                end
                            end else if (in_last) begin
                                err_q   <= 1'b1;
                                tdata_q <= DATA_W'(ErrWord);
                                tlast_q <= 1'b1;
                                ret_q   <= StHdr;
                            end else begin
                                tdata_q <= result;
                                tlast_q <= 1'b0;
                                row_q   <= row_q + CntW'(1);
                                ret_q   <= StMac;
                            end
                        end else begin
                            col_q <= col_q + CntW'(1);
                            if (in_last) begin
                                err_q    <= 1'b1;
                                tdata_q  <= DATA_W'(ErrWord);
                                tlast_q  <= 1'b1;
                                tkeep_q  <= '1;
                                tvalid_q <= 1'b1;
                                ret_q    <= StHdr;
                                state_q  <= StEmit;
                            end
                        end
                    end
                end
                StEmit: begin
                    if (S_AXIS_Send_tready) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tkeep_q  <= '0;
                        state_q  <= ret_q;
                    end
                end
                StDrain: begin
                    if (accept && in_last) begin
                        if (err_pend_q) begin
                            err_pend_q <= 1'b0;
                            tdata_q    <= DATA_W'(ErrWord);
                            tlast_q    <= 1'b1;
                            tkeep_q    <= '1;
                            tvalid_q   <= 1'b1;
                            ret_q      <= StHdr;
                            state_q    <= StEmit;
                        end else begin
                            state_q <= StHdr;
                        end
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    assign S_AXIS_Send_tdata  = tdata_q;
    assign S_AXIS_Send_tkeep  = tkeep_q;
    assign S_AXIS_Send_tvalid = tvalid_q;
    assign S_AXIS_Send_tlast  = tlast_q;
    assign busy               = (state_q != StHdr);
    assign err                = err_q;

endmodule
